// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions for the display driver and reader.
//   seg7_t      7-bit active-low segment pattern, bit6=a ... bit0=g
//   SEG7_BLANK  all segments off
//   SEG7_TABLE  pattern for each hex digit 0..F
package seg7_pkg;
    typedef logic [6:0] seg7_t;
    localparam seg7_t SEG7_BLANK = 7'h7F;
    localparam seg7_t SEG7_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h02, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment pattern to hex digit lookup.
//   pattern  in   7  active-low segment pattern
//   legal    out  1  pattern matches a table entry
//   digit    out  4  matched digit (0 when not legal)
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg7_t       pattern,
    output logic        legal,
    output logic [3:0]  digit
);
    always_comb begin
        legal = 1'b0;
        digit = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG7_TABLE[i]) begin
                legal = 1'b1;
                digit = 4'(i);
            end
        end
    end
endmodule

// File: rtl/seg7_digit_reader.sv
// seg7_digit_reader: filters a 7-segment bus, decodes it and classifies digit changes.
//   clk, rst                    clock; synchronous active-high reset
//   seg_in       in   7         asynchronous active-low segment bus
//   digit        out  4         last accepted legal digit
//   digit_valid  out  1         last accepted pattern was legal
//   step_up      out  1         pulse: digit == prev+1 mod 16
//   step_down    out  1         pulse: digit == prev-1 mod 16
//   wrap         out  1         pulse with a step crossing 15<->0
//   jump_err     out  1         pulse: legal change that is not +-1
//   illegal_err  out  1         pulse: accepted pattern not decodable
//   net_count    out  CNT_W     up steps minus down steps, modulo 2**CNT_W
//   err_count    out  8         saturating error count, built only with
//                               SEG7_READER_ERRCNT_EN, otherwise tied to 0
module seg7_digit_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  seg7_t            seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             wrap,
    output logic             jump_err,
    output logic             illegal_err,
    output logic [CNT_W-1:0] net_count,
    output logic [7:0]       err_count
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    seg7_t s1, s2, cand;
    logic [CW-1:0] cnt;
    logic [3:0] prev, dec_digit;
    logic have_prev, dec_legal, accept, is_up, is_down, is_jump;

    seg7_pattern_decode u_dec (
        .pattern (cand),
        .legal   (dec_legal),
        .digit   (dec_digit)
    );

    // Acceptance is the edge on which cnt reaches CMAX; cnt parks there so a
    // stable value fires only once.
    always_comb begin
        accept  = (s2 == cand) && (cnt == CMAX - 1'b1);
        is_up   = have_prev && (dec_digit == prev + 4'd1);
        is_down = have_prev && (dec_digit == prev - 4'd1) && !is_up;
        is_jump = have_prev && (dec_digit != prev) && !is_up && !is_down;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= SEG7_BLANK;
            s2          <= SEG7_BLANK;
            cand        <= SEG7_BLANK;
            cnt         <= CMAX;
            prev        <= 4'd0;
            have_prev   <= 1'b0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            wrap        <= 1'b0;
            jump_err    <= 1'b0;
            illegal_err <= 1'b0;
            net_count   <= '0;
        end else begin
            s1          <= seg_in;
            s2          <= s1;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            wrap        <= 1'b0;
            jump_err    <= 1'b0;
            illegal_err <= 1'b0;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt < CMAX) begin
                cnt <= cnt + 1'b1;
            end
            if (accept && dec_legal) begin
                digit       <= dec_digit;
                digit_valid <= 1'b1;
                step_up     <= is_up;
                step_down   <= is_down;
                jump_err    <= is_jump;
                wrap        <= (is_up && prev == 4'hF) || (is_down && prev == 4'h0);
                net_count   <= is_up ? net_count + CNT_W'(1) : is_down ? net_count - CNT_W'(1) : net_count;
                prev        <= dec_digit;
                have_prev   <= 1'b1;
            end else if (accept) begin
                illegal_err <= 1'b1;
                digit_valid <= 1'b0;
                have_prev   <= 1'b0;
            end
        end
    end

`ifdef SEG7_READER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= 8'd0;
        else if ((jump_err || illegal_err) && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_seg7_digit_reader.sv
// tb_seg7_digit_reader: table-driven scoreboard bench for seg7_digit_reader.
module tb_seg7_digit_reader;
    localparam int S = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] seg_in = 7'h7F;
    logic [3:0] digit;
    logic digit_valid, step_up, step_down, wrap, jump_err, illegal_err;
    logic [W-1:0] net_count;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    seg7_digit_reader #(.STABLE_CYCLES(S), .CNT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .step_up     (step_up),
        .step_down   (step_down),
        .wrap        (wrap),
        .jump_err    (jump_err),
        .illegal_err (illegal_err),
        .net_count   (net_count),
        .err_count   (err_count)
    );

    typedef struct packed {
        logic [3:0] d;
        logic v, up, dn, wr, jp, il;
    } ev_t;

    typedef struct {
        logic [6:0] pat;
        int         hold;
        logic       evt;
        ev_t        e;
        logic [7:0] net;
    } vec_t;

    ev_t exp_q[$];
    vec_t tbl[$];
    int errors = 0;
    int checks = 0;
    int exp_err = 0;
    logic [3:0] last_d = 4'd0;
    logic last_v = 1'b0;
    ev_t mon_a, mon_e;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] p, input int h, input logic ev,
                                input logic [3:0] d, input logic v, input logic up,
                                input logic dn, input logic wr, input logic jp,
                                input logic il, input logic [7:0] n);
        vec_t r;
        r.pat = p;
        r.hold = h;
        r.evt = ev;
        r.e = '{d: d, v: v, up: up, dn: dn, wr: wr, jp: jp, il: il};
        r.net = n;
        return r;
    endfunction

    function automatic int sat_err(input int n);
`ifdef SEG7_READER_ERRCNT_EN
        return n > 255 ? 255 : n;
`else
        return 0 * n;
`endif
    endfunction

    // Any pulse or change of digit/digit_valid is an observed event and is
    // matched against the oldest expected event.
    always @(negedge clk) begin
        if (rst) begin
            last_d = 4'd0;
            last_v = 1'b0;
        end else if (step_up || step_down || wrap || jump_err || illegal_err ||
                     digit != last_d || digit_valid != last_v) begin
            mon_a = '{d: digit, v: digit_valid, up: step_up, dn: step_down,
                      wr: wrap, jp: jump_err, il: illegal_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event: unexpected %h at %0t", mon_a, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h at %0t", mon_a, mon_e, $time);
                end
            end
            last_d = digit;
            last_v = digit_valid;
        end
    end

    initial begin
        int n;
        // digit tests after an initial 0: steps, wraps, glitches, jumps, illegal
        tbl.push_back(mk(7'h4F, 10, 1, 4'h1, 1, 1, 0, 0, 0, 0, 8'd1));
        tbl.push_back(mk(7'h01, 10, 1, 4'h0, 1, 0, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(7'h38, 10, 1, 4'hF, 1, 0, 1, 1, 0, 0, 8'd255));
        tbl.push_back(mk(7'h01, 10, 1, 4'h0, 1, 1, 0, 1, 0, 0, 8'd0));
        tbl.push_back(mk(7'h06, 10, 1, 4'h3, 1, 0, 0, 0, 1, 0, 8'd0));
        tbl.push_back(mk(7'h00,  4, 0, 4'h3, 1, 0, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(7'h06, 10, 0, 4'h3, 1, 0, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(7'h0F, 10, 1, 4'h7, 1, 0, 0, 0, 1, 0, 8'd0));
        tbl.push_back(mk(7'h7E, 10, 1, 4'h7, 0, 0, 0, 0, 0, 1, 8'd0));
        tbl.push_back(mk(7'h24, 10, 1, 4'h5, 1, 0, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(7'h4C, 10, 1, 4'h4, 1, 0, 1, 0, 0, 0, 8'd255));
        tbl.push_back(mk(7'h30, 10, 1, 4'hE, 1, 0, 0, 0, 1, 0, 8'd255));
        tbl.push_back(mk(7'h20, 10, 1, 4'h6, 1, 0, 0, 0, 1, 0, 8'd255));
        tbl.push_back(mk(7'h0F, 10, 1, 4'h7, 1, 1, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(7'h00, 10, 1, 4'h8, 1, 1, 0, 0, 0, 0, 8'd1));
        tbl.push_back(mk(7'h04, 10, 1, 4'h9, 1, 1, 0, 0, 0, 0, 8'd2));
        tbl.push_back(mk(7'h02, 10, 1, 4'hA, 1, 1, 0, 0, 0, 0, 8'd3));
        tbl.push_back(mk(7'h60, 10, 1, 4'hB, 1, 1, 0, 0, 0, 0, 8'd4));
        tbl.push_back(mk(7'h31, 10, 1, 4'hC, 1, 1, 0, 0, 0, 0, 8'd5));
        tbl.push_back(mk(7'h42, 10, 1, 4'hD, 1, 1, 0, 0, 0, 0, 8'd6));
        tbl.push_back(mk(7'h30, 10, 1, 4'hE, 1, 1, 0, 0, 0, 0, 8'd7));
        tbl.push_back(mk(7'h38, 10, 1, 4'hF, 1, 1, 0, 0, 0, 0, 8'd8));
        tbl.push_back(mk(7'h4F, 10, 1, 4'h1, 1, 0, 0, 0, 1, 0, 8'd8));
        tbl.push_back(mk(7'h12, 10, 1, 4'h2, 1, 1, 0, 0, 0, 0, 8'd9));
        tbl.push_back(mk(7'h7F, 10, 1, 4'h2, 0, 0, 0, 0, 0, 1, 8'd9));

        // reset with a blank bus: nothing may happen
        rst = 1'b1;
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset_digit", int'(digit), 0);
        chk("reset_valid", int'(digit_valid), 0);
        chk("reset_net", int'(net_count), 0);
        chk("reset_err", int'(err_count), 0);

        // first digit after reset: reference only, lands on edge 3+S
        seg_in = 7'h01;
        exp_q.push_back('{d: 4'h0, v: 1'b1, up: 1'b0, dn: 1'b0, wr: 1'b0, jp: 1'b0, il: 1'b0});
        repeat (S + 2) @(negedge clk);
        chk("latency_before", int'(digit_valid), 0);
        @(negedge clk);
        chk("latency_at", int'(digit_valid), 1);
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            if (tbl[i].evt) begin
                exp_q.push_back(tbl[i].e);
                if (tbl[i].e.jp || tbl[i].e.il)
                    exp_err++;
            end
            seg_in = tbl[i].pat;
            repeat (tbl[i].hold) @(negedge clk);
            chk($sformatf("net_%0d", i), int'(net_count), int'(tbl[i].net));
            chk($sformatf("err_%0d", i), int'(err_count), sat_err(exp_err));
        end

        // back-to-back illegal patterns at the minimum accepted hold of S+1
`ifdef SEG7_READER_ERRCNT_EN
        n = 300;
`else
        n = 4;
`endif
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{d: 4'h2, v: 1'b0, up: 1'b0, dn: 1'b0, wr: 1'b0, jp: 1'b0, il: 1'b1});
            exp_err++;
            seg_in = (i % 2 == 1) ? 7'h7F : 7'h7E;
            repeat (S + 1) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("burst_err", int'(err_count), sat_err(exp_err));
        chk("burst_net", int'(net_count), 9);
        chk("queue_drained", exp_q.size(), 0);

        // reset while a new pattern is still in the filter
        seg_in = 7'h4F;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seg_in = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_digit", int'(digit), 0);
        chk("midrst_valid", int'(digit_valid), 0);
        chk("midrst_net", int'(net_count), 0);
        chk("midrst_err", int'(err_count), 0);
        chk("midrst_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
